// File: rtl/uart_rcvr.sv
// Oversampling UART receiver: start-bit validation, LSB-first data capture,
// stop-bit check, ready/ack handshake with sticky overrun and framing flags.
module uart_rcvr #(
    parameter int WORD_SIZE  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int CNT_W      = 3
) (
    input  logic                 Clock,
    input  logic                 rst,
    input  logic                 Serial_in,
    input  logic                 Rcv_ack,
    output logic [WORD_SIZE-1:0] RCV_datareg,
    output logic                 Rcv_ready,
    output logic                 Error1,
    output logic                 Error2
);
    localparam int BIT_W = $clog2(WORD_SIZE + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] STARTING  = 2'd1;
    localparam logic [1:0] RECEIVING = 2'd2;

    logic [1:0]           state_q,      state_d;
    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [WORD_SIZE-1:0] shift_q,      shift_d;
    logic [WORD_SIZE-1:0] data_q,       data_d;
    logic                 ready_q,      ready_d;
    logic                 err1_q,       err1_d;
    logic                 err2_q,       err2_d;

    logic sample_point;
    logic stop_point;

    assign sample_point = (sample_cnt_q == CNT_W'(OVERSAMPLE - 1));
    assign stop_point   = (bit_cnt_q == BIT_W'(WORD_SIZE));

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        ready_d      = ready_q;
        err1_d       = err1_q;
        err2_d       = err2_q;

        // A good load later in this block overrides the ack clear.
        if (Rcv_ack) begin
            ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                bit_cnt_d    = '0;
                if (!Serial_in) begin
                    state_d = STARTING;
                end
            end
            STARTING: begin
                if (Serial_in) begin
                    state_d      = IDLE;
                    sample_cnt_d = '0;
                end else if (sample_cnt_q == CNT_W'(OVERSAMPLE / 2 - 1)) begin
                    state_d      = RECEIVING;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            RECEIVING: begin
                if (sample_point) begin
                    sample_cnt_d = '0;
                    if (stop_point) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        if (!Serial_in) begin
                            err2_d = 1'b1;
                        end else if (ready_q && !Rcv_ack) begin
                            err1_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            err1_d  = 1'b0;
                            err2_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = {Serial_in, shift_q[WORD_SIZE-1:1]};
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                sample_cnt_d = '0;
                bit_cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            err1_q       <= 1'b0;
            err2_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            err1_q       <= err1_d;
            err2_q       <= err2_d;
        end
    end

    assign RCV_datareg = data_q;
    assign Rcv_ready   = ready_q;
    assign Error1      = err1_q;
    assign Error2      = err2_q;
endmodule

// File: tb/tb_uart_rcvr.sv
// Directed bench for uart_rcvr: table of back-to-back frames plus hand-written
// reset, timing, glitch and break sequences.
module tb_uart_rcvr;
    localparam int WS = 8;
    localparam int OS = 8;

    logic          Clock = 1'b0;
    logic          rst = 1'b1;
    logic          Serial_in = 1'b1;
    logic          Rcv_ack = 1'b0;
    logic [WS-1:0] RCV_datareg;
    logic          Rcv_ready;
    logic          Error1;
    logic          Error2;

    uart_rcvr #(.WORD_SIZE(WS), .OVERSAMPLE(OS), .CNT_W(3)) dut (
        .Clock      (Clock),
        .rst        (rst),
        .Serial_in  (Serial_in),
        .Rcv_ack    (Rcv_ack),
        .RCV_datareg(RCV_datareg),
        .Rcv_ready  (Rcv_ready),
        .Error1     (Error1),
        .Error2     (Error2)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         idle;
        logic [7:0] data;
        logic       stop;
        logic       ack_first;
        logic       ack_load;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_e1;
        logic       exp_e2;
    } vec_t;

    vec_t vecs[13];

    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    int   start_edge = 0;
    int   rise_edge = -1;
    logic rdy_prev = 1'b0;

    always @(posedge Clock) edge_cnt <= edge_cnt + 1;

    always @(negedge Clock) begin
        if (Rcv_ready && !rdy_prev) rise_edge <= edge_cnt;
        rdy_prev <= Rcv_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        Serial_in = 1'b1;
        repeat (n) @(negedge Clock);
    endtask

    // Bit b is held for OS clocks; iteration i of the stop bit covers edge E(72+i).
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic ack_first, input logic ack_load);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        start_edge = edge_cnt + 1;
        for (int b = 0; b < 10; b++) begin
            Serial_in = bits[b];
            for (int i = 0; i < OS; i++) begin
                Rcv_ack = (b == 0 && i == 0 && ack_first) ||
                          (b == 9 && i == OS / 2 && ack_load);
                @(negedge Clock);
            end
        end
        Rcv_ack   = 1'b0;
        Serial_in = 1'b1;
    endtask

    task automatic ack_pulse();
        Rcv_ack = 1'b1;
        @(negedge Clock);
        Rcv_ack = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic r,
                           input logic e1, input logic e2);
        chk({tag, ".data"},  32'(RCV_datareg), 32'(d));
        chk({tag, ".ready"}, 32'(Rcv_ready),   32'(r));
        chk({tag, ".err1"},  32'(Error1),      32'(e1));
        chk({tag, ".err2"},  32'(Error2),      32'(e2));
        $display("%s: data=%02h ready=%0b err1=%0b err2=%0b", tag, RCV_datareg,
                 Rcv_ready, Error1, Error2);
    endtask

    initial begin
        vecs[0]  = '{0, 8'h41, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'h42, 1'b1, 1'b1, 1'b0, 8'h42, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0, 8'h43, 1'b1, 1'b1, 1'b0, 8'h43, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h43, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{4, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{0, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{0, 8'h77, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{4, 8'h99, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge Clock);
        rst = 1'b0;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Single frame with latency measured from the start edge.
        idle(4);
        rise_edge = -1;
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        chk_out("single", 8'h41, 1'b1, 1'b0, 1'b0);
        chk("single.latency", 32'(rise_edge - start_edge), 32'd76);

        // Asynchronous reset in the middle of a frame.
        Serial_in = 1'b0;
        repeat (20) @(negedge Clock);
        #2 rst = 1'b1;
        #1 chk_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
        Serial_in = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        rst = 1'b0;
        idle(2);
        chk_out("postreset", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        chk_out("afterreset", 8'h41, 1'b1, 1'b0, 1'b0);
        ack_pulse();
        chk("ack.clear", 32'(Rcv_ready), 32'd0);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].idle > 0) idle(vecs[v].idle);
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_first, vecs[v].ack_load);
            chk_out($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ready,
                    vecs[v].exp_e1, vecs[v].exp_e2);
        end

        // Short low glitch must be rejected without side effects.
        ack_pulse();
        Serial_in = 1'b0;
        repeat (2) @(negedge Clock);
        idle(20);
        chk_out("glitch", 8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        chk_out("postglitch", 8'h55, 1'b1, 1'b0, 1'b0);

        // Break: line held low produces framing errors, then recovery.
        Serial_in = 1'b0;
        repeat (300) @(negedge Clock);
        chk_out("break", 8'h55, 1'b1, 1'b0, 1'b1);
        idle(20);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        chk_out("postbreak", 8'hC3, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
